hog_bin_collector: RTL and testbench

HOG_BIN_COLLECTOR -- requirements
Module: hog_bin_collector

---
 rtl/hog_bin_collector_if.sv | 36 +++
 rtl/hog_bin_collector.sv | 148 ++++++++++++++
 tb/tb_hog_bin_collector.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hog_bin_collector_if.sv
// Bundle between the HOG histogram stage, the block collector and the downstream bin consumer.
// The slave modport is the collector's view; the master modport is the producer/consumer side.
interface hog_bin_collector_if #(
    parameter int unsigned BIN_W = 32
);
    logic [BIN_W-1:0]   iBIN1;
    logic [BIN_W-1:0]   iBIN2;
    logic [BIN_W-1:0]   iBIN3;
    logic [BIN_W-1:0]   iBIN4;
    logic [BIN_W-1:0]   iBIN5;
    logic [BIN_W-1:0]   iBIN6;
    logic [BIN_W-1:0]   iBIN7;
    logic [BIN_W-1:0]   iBIN8;
    logic [BIN_W-1:0]   iBIN9;
    logic               iDONE;
    logic               iREADY;
    logic [BIN_W-1:0]   oBIN;
    logic [5:0]         oIDX;
    logic               oVALID;
    logic               oLAST;
    logic [BIN_W+5:0]   oNORM_SUM;
    logic               oOVF;
    logic [15:0]        oBLK_CNT;

    modport master (
        output iBIN1, iBIN2, iBIN3, iBIN4, iBIN5, iBIN6, iBIN7, iBIN8, iBIN9,
        output iDONE, iREADY,
        input  oBIN, oIDX, oVALID, oLAST, oNORM_SUM, oOVF, oBLK_CNT
    );

    modport slave (
        input  iBIN1, iBIN2, iBIN3, iBIN4, iBIN5, iBIN6, iBIN7, iBIN8, iBIN9,
        input  iDONE, iREADY,
        output oBIN, oIDX, oVALID, oLAST, oNORM_SUM, oOVF, oBLK_CNT
    );
endinterface

// File: rtl/hog_bin_collector.sv
// Gathers four 9-bin HOG cells into one 36-bin 2x2 block, then streams it out with a
// valid/ready handshake alongside the block's L1 sum.
module hog_bin_collector #(
    parameter int unsigned BIN_W = 32
) (
    input logic                 iClk,
    input logic                 iRst,
    hog_bin_collector_if.slave  bus
);
    localparam int unsigned SumW = BIN_W + 6;
    localparam logic [5:0]  LastIdx = 6'd35;

    typedef enum logic {StCollect, StStream} state_e;

    state_e           state_q, state_d;
    logic [1:0]       cell_cnt_q, cell_cnt_d;
    logic [SumW-1:0]  acc_q, acc_d;
    logic [SumW-1:0]  norm_q, norm_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [5:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      blk_cnt_q, blk_cnt_d;

    logic             capture;
    logic [SumW-1:0]  cell_sum;
    logic [5:0]       cell_base;
    logic [5:0]       idx_next;
    logic [BIN_W-1:0] cell_bins [9];
    logic [BIN_W-1:0] bin_mem [36];

    assign cell_bins[0] = bus.iBIN1;
    assign cell_bins[1] = bus.iBIN2;
    assign cell_bins[2] = bus.iBIN3;
    assign cell_bins[3] = bus.iBIN4;
    assign cell_bins[4] = bus.iBIN5;
    assign cell_bins[5] = bus.iBIN6;
    assign cell_bins[6] = bus.iBIN7;
    assign cell_bins[7] = bus.iBIN8;
    assign cell_bins[8] = bus.iBIN9;

    // Six extra bits hold 36 full-scale bins, so the sum never wraps.
    always_comb begin
        cell_sum = '0;
        for (int k = 0; k < 9; k++) begin
            cell_sum = cell_sum + SumW'(cell_bins[k]);
        end
    end

    assign cell_base = 6'(cell_cnt_q) * 6'd9;
    assign idx_next  = idx_q + 6'd1;

    always_comb begin
        state_d    = state_q;
        cell_cnt_d = cell_cnt_q;
        acc_d      = acc_q;
        norm_d     = norm_q;
        bin_d      = bin_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        last_d     = last_q;
        ovf_d      = ovf_q;
        blk_cnt_d  = blk_cnt_q;
        capture    = 1'b0;

        unique case (state_q)
            StCollect: begin
                if (bus.iDONE) begin
                    capture    = 1'b1;
                    cell_cnt_d = cell_cnt_q + 2'd1;
                    acc_d      = (cell_cnt_q == 2'd0) ? cell_sum : acc_q + cell_sum;
                    if (cell_cnt_q == 2'd3) begin
                        // Cell 0 is already in the buffer, so beat 0 can be read now.
                        state_d = StStream;
                        norm_d  = acc_q + cell_sum;
                        idx_d   = 6'd0;
                        bin_d   = bin_mem[0];
                        valid_d = 1'b1;
                        last_d  = 1'b0;
                    end
                end
            end
            StStream: begin
                if (bus.iDONE) begin
                    ovf_d = 1'b1;
                end
                if (bus.iREADY) begin
                    if (idx_q == LastIdx) begin
                        state_d    = StCollect;
                        cell_cnt_d = 2'd0;
                        idx_d      = 6'd0;
                        valid_d    = 1'b0;
                        last_d     = 1'b0;
                        blk_cnt_d  = blk_cnt_q + 16'd1;
                    end else begin
                        idx_d  = idx_next;
                        bin_d  = bin_mem[idx_next];
                        last_d = (idx_next == LastIdx);
                    end
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= StCollect;
            cell_cnt_q <= '0;
            acc_q      <= '0;
            norm_q     <= '0;
            bin_q      <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            ovf_q      <= 1'b0;
            blk_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cell_cnt_q <= cell_cnt_d;
            acc_q      <= acc_d;
            norm_q     <= norm_d;
            bin_q      <= bin_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            ovf_q      <= ovf_d;
            blk_cnt_q  <= blk_cnt_d;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst && capture) begin
            for (int k = 0; k < 9; k++) begin
                bin_mem[cell_base + 6'(k)] <= cell_bins[k];
            end
        end
    end

    assign bus.oBIN      = bin_q;
    assign bus.oIDX      = idx_q;
    assign bus.oVALID    = valid_q;
    assign bus.oLAST     = last_q;
    assign bus.oNORM_SUM = norm_q;
    assign bus.oOVF      = ovf_q;
    assign bus.oBLK_CNT  = blk_cnt_q;
endmodule

// File: tb/tb_hog_bin_collector.sv
// Directed bench for hog_bin_collector: block capture, streaming with stalls, overflow,
// full-scale sums, mid-stream reset and block counter wrap.
module tb_hog_bin_collector;
    localparam int unsigned BIN_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hog_bin_collector_if #(.BIN_W(BIN_W)) bus ();

    hog_bin_collector #(.BIN_W(BIN_W)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    int               vec_cnt = 0;
    int               err_cnt = 0;
    logic [BIN_W-1:0] exp_bin [36];
    logic [BIN_W+5:0] exp_norm;
    logic [15:0]      exp_blk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BIN_W-1:0] bin_val(input int k, input int b, input int kind);
        case (kind)
            0:       return BIN_W'(10 * k + b);
            1:       return '1;
            2:       return BIN_W'(999);
            default: return BIN_W'(1000 + 10 * k + b);
        endcase
    endfunction

    task automatic pulse_cell(input int k, input int kind);
        bus.iBIN1 = bin_val(k, 1, kind);
        bus.iBIN2 = bin_val(k, 2, kind);
        bus.iBIN3 = bin_val(k, 3, kind);
        bus.iBIN4 = bin_val(k, 4, kind);
        bus.iBIN5 = bin_val(k, 5, kind);
        bus.iBIN6 = bin_val(k, 6, kind);
        bus.iBIN7 = bin_val(k, 7, kind);
        bus.iBIN8 = bin_val(k, 8, kind);
        bus.iBIN9 = bin_val(k, 9, kind);
        bus.iDONE = 1'b1;
        tick();
        bus.iDONE = 1'b0;
    endtask

    // Ends one cycle after the 4th iDONE edge, where beat 0 must already be valid.
    task automatic send_block(input int spacing, input int kind);
        exp_norm = '0;
        for (int k = 0; k < 4; k++) begin
            pulse_cell(k, kind);
            for (int b = 1; b <= 9; b++) begin
                exp_bin[9 * k + b - 1] = bin_val(k, b, kind);
                exp_norm = exp_norm + (BIN_W + 6)'(bin_val(k, b, kind));
            end
            if (k < 3) repeat (spacing - 1) tick();
        end
        vec_cnt++;
        if (bus.oVALID !== 1'b1 || bus.oIDX !== 6'd0) begin
            err_cnt++;
            $display("FAIL first_beat: valid=%b idx=%0d, required valid=1 idx=0",
                     bus.oVALID, bus.oIDX);
        end
    endtask

    // pattern 0: ready always high; pattern 1: ready 1,0,0,1 repeating.
    task automatic drain(input int pattern, input int stop_at, output int beats);
        int   e   = 0;
        int   cyc = 0;
        logic rdy;
        while (e < 36 && e != stop_at && cyc < 500) begin
            rdy = (pattern == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            bus.iREADY = rdy;
            vec_cnt++;
            if (bus.oVALID !== 1'b1 || bus.oIDX !== 6'(e) || bus.oBIN !== exp_bin[e] ||
                bus.oLAST !== (e == 35)) begin
                err_cnt++;
                $display("FAIL beat%0d: valid=%b idx=%0d bin=%0h last=%b, required 1 %0d %0h %b",
                         e, bus.oVALID, bus.oIDX, bus.oBIN, bus.oLAST, e, exp_bin[e], e == 35);
            end
            tick();
            if (rdy) e++;
            cyc++;
        end
        bus.iREADY = 1'b0;
        beats = e;
        if (cyc >= 500) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL drain_timeout: %0d beats seen, required %0d", e, stop_at);
        end else if (e == 36) begin
            vec_cnt++;
            if (bus.oVALID !== 1'b0 || bus.oBLK_CNT !== exp_blk) begin
                err_cnt++;
                $display("FAIL block_end: valid=%b blk=%0d, required valid=0 blk=%0d",
                         bus.oVALID, bus.oBLK_CNT, exp_blk);
            end
        end
    endtask

    task automatic test_reset();
        bus.iREADY = 1'b0;
        bus.iDONE  = 1'b1;  // must be ignored while in reset
        rst = 1'b1;
        repeat (3) tick();
        bus.iDONE = 1'b0;
        rst = 1'b0;
        tick();
        vec_cnt++;
        if (bus.oVALID !== 1'b0 || bus.oIDX !== 6'd0 || bus.oBIN !== '0 ||
            bus.oLAST !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_stream: valid=%b idx=%0d bin=%0h last=%b, required all 0",
                     bus.oVALID, bus.oIDX, bus.oBIN, bus.oLAST);
        end
        vec_cnt++;
        if (bus.oNORM_SUM !== '0 || bus.oOVF !== 1'b0 || bus.oBLK_CNT !== 16'd0) begin
            err_cnt++;
            $display("FAIL reset_status: norm=%0h ovf=%b blk=%0d, required all 0",
                     bus.oNORM_SUM, bus.oOVF, bus.oBLK_CNT);
        end
    endtask

    task automatic test_basic_block();
        int beats;
        send_block(116, 0);
        exp_blk = 16'd1;
        vec_cnt++;
        if (bus.oNORM_SUM !== 38'd720 || exp_norm !== 38'd720) begin
            err_cnt++;
            $display("FAIL basic_norm: got %0d, required 720", bus.oNORM_SUM);
        end
        drain(0, 36, beats);
        repeat (5) tick();
        vec_cnt++;
        if (bus.oNORM_SUM !== 38'd720 || bus.oVALID !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_hold: norm=%0d valid=%b, required 720 0",
                     bus.oNORM_SUM, bus.oVALID);
        end
    endtask

    task automatic test_back_to_back();
        int beats;
        send_block(3, 0);
        exp_blk = 16'd2;
        drain(1, 36, beats);
        vec_cnt++;
        if (beats !== 36) begin
            err_cnt++;
            $display("FAIL stall_transfers: got %0d, required 36", beats);
        end
    endtask

    task automatic test_overflow();
        int beats;
        send_block(2, 0);
        exp_blk = 16'd3;
        repeat (3) tick();
        pulse_cell(0, 2);
        tick();
        vec_cnt++;
        if (bus.oOVF !== 1'b1 || bus.oIDX !== 6'd0 || bus.oBIN !== exp_bin[0]) begin
            err_cnt++;
            $display("FAIL ovf_set: ovf=%b idx=%0d bin=%0h, required 1 0 %0h",
                     bus.oOVF, bus.oIDX, bus.oBIN, exp_bin[0]);
        end
        drain(0, 36, beats);
        vec_cnt++;
        if (bus.oOVF !== 1'b1 || bus.oNORM_SUM !== 38'd720) begin
            err_cnt++;
            $display("FAIL ovf_sticky: ovf=%b norm=%0d, required 1 720",
                     bus.oOVF, bus.oNORM_SUM);
        end
    endtask

    task automatic test_full_scale();
        int beats;
        send_block(2, 1);
        exp_blk = 16'd4;
        vec_cnt++;
        if (bus.oNORM_SUM !== 38'h23_FFFF_FFDC) begin
            err_cnt++;
            $display("FAIL full_scale_norm: got %0h, required 23ffffffdc", bus.oNORM_SUM);
        end
        drain(0, 36, beats);
    endtask

    task automatic test_reset_mid_stream();
        int beats;
        send_block(2, 0);
        drain(0, 17, beats);
        vec_cnt++;
        if (bus.oIDX !== 6'd17 || bus.oVALID !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_idx: idx=%0d valid=%b, required 17 1", bus.oIDX, bus.oVALID);
        end
        rst = 1'b1;
        bus.iREADY = 1'b1;
        tick();
        rst = 1'b0;
        bus.iREADY = 1'b0;
        vec_cnt++;
        if (bus.oVALID !== 1'b0 || bus.oBLK_CNT !== 16'd0 || bus.oOVF !== 1'b0 ||
            bus.oNORM_SUM !== '0) begin
            err_cnt++;
            $display("FAIL mid_reset: valid=%b blk=%0d ovf=%b norm=%0h, required all 0",
                     bus.oVALID, bus.oBLK_CNT, bus.oOVF, bus.oNORM_SUM);
        end
        send_block(4, 3);
        exp_blk = 16'd1;
        vec_cnt++;
        if (bus.oNORM_SUM !== exp_norm) begin
            err_cnt++;
            $display("FAIL fresh_norm: got %0d, required %0d", bus.oNORM_SUM, exp_norm);
        end
        drain(0, 36, beats);
    endtask

    // Counter is preloaded near the top so the wrap takes one block instead of 65536.
    task automatic test_blk_wrap();
        int beats;
        force dut.blk_cnt_q = 16'hFFFF;
        tick();
        release dut.blk_cnt_q;
        send_block(2, 0);
        exp_blk = 16'd0;
        drain(0, 36, beats);
    endtask

    initial begin
        bus.iBIN1 = '0; bus.iBIN2 = '0; bus.iBIN3 = '0;
        bus.iBIN4 = '0; bus.iBIN5 = '0; bus.iBIN6 = '0;
        bus.iBIN7 = '0; bus.iBIN8 = '0; bus.iBIN9 = '0;
        bus.iDONE  = 1'b0;
        bus.iREADY = 1'b0;
        exp_blk    = 16'd0;
        exp_norm   = '0;
        test_reset();
        test_basic_block();
        test_back_to_back();
        test_overflow();
        test_full_scale();
        test_reset_mid_stream();
        test_blk_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
